// File: rtl/amux_seq_pkg.sv
// Shared types and constants for the analog-mux ADC sequencer.
// Also holds the channel-target rule used wherever a new channel is chosen.
package amux_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StStart,
        StWait
    } state_e;

    localparam logic [1:0] MODE_CH0 = 2'b00;
    localparam logic [1:0] MODE_CH1 = 2'b01;
    localparam logic [1:0] MODE_ALT = 2'b10;

    localparam int unsigned DEFAULT_ADC_W = 12;

    // Alternation always restarts on channel 0 when leaving idle.
    function automatic logic target_ch(input logic [1:0] mode, input logic cur_sel,
                                       input logic from_idle);
        logic t;
        case (mode)
            MODE_CH1: t = 1'b1;
            MODE_ALT: t = from_idle ? 1'b0 : ~cur_sel;
            default:  t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/amux_seq_cnt.sv
// Loadable down-counter with zero flag; times both the settle delay and the
// conversion timeout.
module amux_seq_cnt #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/amux_seq_ctrl.sv
// Analog-mux select sequencer: chooses the channel, waits for settling, runs
// the ADC start/done handshake and files results per channel.
module amux_seq_ctrl
    import amux_seq_pkg::*;
#(
    parameter int unsigned SETTLE_W = 8,
    parameter int unsigned ADC_W    = DEFAULT_ADC_W,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [SETTLE_W-1:0] settle_cycles,
    input  logic                clear_err,
    output logic                sel,
    output logic                adc_start,
    input  logic                adc_done,
    input  logic [ADC_W-1:0]    adc_data,
    output logic [ADC_W-1:0]    ch0_data,
    output logic [ADC_W-1:0]    ch1_data,
    output logic                ch0_valid,
    output logic                ch1_valid,
    output logic                busy,
    output logic                timeout_err
);

    localparam int unsigned CNT_W = (SETTLE_W > 10) ? SETTLE_W : 10;

    state_e           state_q, state_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val, cnt;
    logic             target, sel_d;
    logic             start_d, busy_d, err_d, done_hit;
    logic             ch0_valid_d, ch1_valid_d;

    amux_seq_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .resetn   (resetn),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    assign target = target_ch(mode, sel, state_q == StIdle);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            sel         <= 1'b0;
            adc_start   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            ch0_data    <= '0;
            ch1_data    <= '0;
            ch0_valid   <= 1'b0;
            ch1_valid   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel         <= sel_d;
            adc_start   <= start_d;
            busy        <= busy_d;
            timeout_err <= err_d;
            ch0_valid   <= ch0_valid_d;
            ch1_valid   <= ch1_valid_d;
            if (ch0_valid_d) ch0_data <= adc_data;
            if (ch1_valid_d) ch1_data <= adc_data;
        end
    end

    // sel only moves on entry to SETTLE, so it is frozen across a conversion.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = CNT_W'(settle_cycles);
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    sel_d    = target;
                    cnt_load = 1'b1;
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                if (!enable)       state_d = StIdle;
                else if (cnt_zero) state_d = StStart;
                else               cnt_dec = 1'b1;
            end
            StStart: begin
                cnt_load     = 1'b1;
                cnt_load_val = CNT_W'(TIMEOUT);
                state_d      = StWait;
            end
            StWait: begin
                if (adc_done) begin
                    if (!enable) begin
                        state_d = StIdle;
                    end else if (target != sel) begin
                        sel_d    = target;
                        cnt_load = 1'b1;
                        state_d  = StSettle;
                    end else begin
                        state_d = StStart;
                    end
                end else if (cnt_zero) begin
                    state_d = StIdle;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        start_d     = (state_d == StStart);
        busy_d      = (state_d != StIdle);
        done_hit    = (state_q == StWait) && adc_done;
        ch0_valid_d = done_hit && !sel;
        ch1_valid_d = done_hit && sel;
        err_d       = timeout_err;
        if (clear_err) err_d = 1'b0;
        // A timeout in the same cycle as clear_err takes priority.
        if ((state_q == StWait) && !adc_done && cnt_zero) err_d = 1'b1;
    end

endmodule

// File: tb/tb_amux_seq_ctrl.sv
// Scoreboard bench for amux_seq_ctrl: a reactive ADC model pushes expected
// results, a monitor pops them on every valid strobe.
module tb_amux_seq_ctrl;

    localparam int unsigned SETTLE_W = 8;
    localparam int unsigned ADC_W    = 12;
    localparam int unsigned TIMEOUT  = 15;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic                enable = 1'b0;
    logic [1:0]          mode = 2'b00;
    logic [SETTLE_W-1:0] settle_cycles = '0;
    logic                clear_err = 1'b0;
    logic                sel, adc_start, adc_done;
    logic [ADC_W-1:0]    adc_data;
    logic [ADC_W-1:0]    ch0_data, ch1_data;
    logic                ch0_valid, ch1_valid, busy, timeout_err;

    always #5 clk = ~clk;

    amux_seq_ctrl #(
        .SETTLE_W (SETTLE_W),
        .ADC_W    (ADC_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .enable        (enable),
        .mode          (mode),
        .settle_cycles (settle_cycles),
        .clear_err     (clear_err),
        .sel           (sel),
        .adc_start     (adc_start),
        .adc_done      (adc_done),
        .adc_data      (adc_data),
        .ch0_data      (ch0_data),
        .ch1_data      (ch1_data),
        .ch0_valid     (ch0_valid),
        .ch1_valid     (ch1_valid),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    typedef struct {
        logic             ch;
        logic [ADC_W-1:0] data;
    } exp_t;

    exp_t             exp_q[$];
    int               n_tests = 0, n_fail = 0;
    int               cur_s = 0, conv_idx = 0, lat_min = 1, lat_max = 1;
    logic [1:0]       cur_mode = 2'b00;
    bit               resp_on = 1'b1, resp_rand = 1'b0, inject = 1'b0;
    logic [ADC_W-1:0] resp_d0 = '0, resp_d1 = '0, inject_data = '0, rd = '0;
    logic [ADC_W-1:0] model_last [2];
    int               n_starts = 0, n_valid = 0, ncyc = 0, last_done_n = -1, wait_n = -1;
    logic             last_ch = 1'b0, cur_ch = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Channel of the idx-th conversion since leaving idle.
    function automatic logic model_ch(input logic [1:0] m, input int idx);
        if (m == 2'b01) return 1'b1;
        if (m == 2'b10) return (idx % 2) == 1;
        return 1'b0;
    endfunction

    // ADC model: answers each start after a random latency.
    initial begin
        adc_done = 1'b0;
        adc_data = '0;
        model_last[0] = '0;
        model_last[1] = '0;
        forever begin
            @(negedge clk);
            ncyc++;
            adc_done = 1'b0;
            if (!resetn) wait_n = -1;
            if (inject) begin
                adc_done = 1'b1;
                adc_data = inject_data;
                inject   = 1'b0;
            end else if (wait_n == 0) begin
                rd = resp_rand ? ADC_W'($urandom) : (cur_ch ? resp_d1 : resp_d0);
                adc_done = 1'b1;
                adc_data = rd;
                exp_q.push_back('{ch: cur_ch, data: rd});
                model_last[cur_ch] = rd;
                check("sel_stable_in_wait", 32'(sel), 32'(cur_ch));
                last_done_n = ncyc;
                last_ch     = cur_ch;
                wait_n      = -1;
            end else if (wait_n > 0) begin
                wait_n--;
            end
            if (resetn && adc_start) begin
                n_starts++;
                cur_ch = model_ch(cur_mode, conv_idx);
                conv_idx++;
                check("sel_at_start", 32'(sel), 32'(cur_ch));
                if (last_done_n >= 0)
                    check("done_to_start_gap", ncyc - last_done_n,
                          (cur_ch == last_ch) ? 1 : cur_s + 2);
                last_done_n = -1;
                if (resp_on) wait_n = int'($urandom_range(lat_max, lat_min)) - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (resetn && (ch0_valid || ch1_valid)) begin
            n_valid++;
            check("one_valid_at_a_time", 32'(ch0_valid & ch1_valid), 0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got ch0_valid=%0b ch1_valid=%0b, expected none",
                         ch0_valid, ch1_valid);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("valid_channel", 32'(ch1_valid), 32'(e.ch));
                check("channel_data", 32'(ch1_valid ? ch1_data : ch0_data), 32'(e.data));
            end
        end
    end

    task automatic start_run(input logic [1:0] m, input int s);
        int n;
        n = 0;
        @(negedge clk);
        mode          = m;
        settle_cycles = SETTLE_W'(s);
        cur_mode      = m;
        cur_s         = s;
        conv_idx      = 0;
        last_done_n   = -1;
        enable        = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!adc_start && n < 300);
        check("enable_to_start", n, s + 2);
    endtask

    task automatic wait_valids(input int target);
        int n;
        n = 0;
        while (n_valid < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("valid_count_reached", 32'(n_valid >= target), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("busy_low_in_idle", 32'(busy), 0);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel"}, 32'(sel), 0);
        check({tag, "_adc_start"}, 32'(adc_start), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 0);
        check({tag, "_ch0_data"}, 32'(ch0_data), 0);
        check({tag, "_ch1_data"}, 32'(ch1_data), 0);
        check({tag, "_ch0_valid"}, 32'(ch0_valid), 0);
        check({tag, "_ch1_valid"}, 32'(ch1_valid), 0);
    endtask

    initial begin
        int v0, s0, n;
        logic [1:0] m;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;

        // Fixed channel 0, one conversion.
        resp_d0 = 12'h5A5; lat_min = 3; lat_max = 3;
        start_run(2'b00, 3);
        wait_valids(1);
        enable = 1'b0;
        wait_idle();
        check("fixed_ch0_data", 32'(ch0_data), 'h5A5);

        // Alternate mode: channels toggle and settle after every result.
        resp_d0 = 12'h111; resp_d1 = 12'h222; lat_min = 5; lat_max = 5;
        v0 = n_valid;
        start_run(2'b10, 2);
        wait_valids(v0 + 4);
        enable = 1'b0;
        wait_idle();
        check("alt_ch0_data", 32'(ch0_data), 'h111);
        check("alt_ch1_data", 32'(ch1_data), 'h222);

        // Fixed channel 1, back-to-back with random data and latency.
        resp_rand = 1'b1; lat_min = 1; lat_max = 6;
        v0 = n_valid;
        start_run(2'b01, 5);
        wait_valids(v0 + 6);
        enable = 1'b0;
        wait_idle();

        // Enable dropped while settling: no conversion is started.
        s0 = n_starts;
        @(negedge clk);
        mode = 2'b00; settle_cycles = 8'd10; enable = 1'b1;
        repeat (4) @(negedge clk);
        check("busy_in_settle", 32'(busy), 1);
        enable = 1'b0;
        repeat (20) @(negedge clk);
        check("no_start_after_settle_abort", n_starts, s0);
        check("idle_after_settle_abort", 32'(busy), 0);

        // Enable dropped while waiting: the result is still stored.
        resp_rand = 1'b0; resp_d0 = 12'h3C3; lat_min = 8; lat_max = 8;
        v0 = n_valid;
        start_run(2'b00, 0);
        repeat (2) @(negedge clk);
        enable = 1'b0;
        wait_valids(v0 + 1);
        wait_idle();
        check("wait_abort_data", 32'(ch0_data), 'h3C3);
        check("wait_abort_one_result", n_valid, v0 + 1);

        // Randomised runs across all modes.
        resp_rand = 1'b1; lat_min = 1; lat_max = 8;
        for (int i = 0; i < 6; i++) begin
            m = 2'($urandom_range(3, 0));
            v0 = n_valid;
            start_run(m, int'($urandom_range(7, 0)));
            wait_valids(v0 + int'($urandom_range(5, 2)));
            enable = 1'b0;
            wait_idle();
            check("rand_ch0_data", 32'(ch0_data), 32'(model_last[0]));
            check("rand_ch1_data", 32'(ch1_data), 32'(model_last[1]));
        end

        // ADC never answers: timeout, then a late done is ignored.
        resp_on = 1'b0;
        start_run(2'b00, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!timeout_err && n < 100);
        check("timeout_latency", n, TIMEOUT + 2);
        check("idle_after_timeout", 32'(busy), 0);
        enable = 1'b0;
        v0 = n_valid;
        inject_data = 12'hFFF;
        inject = 1'b1;
        repeat (4) @(negedge clk);
        check("late_done_no_valid", n_valid, v0);
        check("late_done_ch0_kept", 32'(ch0_data), 32'(model_last[0]));
        check("timeout_err_sticky", 32'(timeout_err), 1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("timeout_err_cleared", 32'(timeout_err), 0);

        // Asynchronous reset in the middle of a wait.
        start_run(2'b01, 0);
        repeat (3) @(negedge clk);
        check("busy_before_reset", 32'(busy), 1);
        #2 resetn = 1'b0;
        #1 check_reset_outputs("async_reset");
        enable = 1'b0;
        model_last[0] = '0;
        model_last[1] = '0;
        @(negedge clk);
        resetn = 1'b1;
        v0 = n_valid;
        inject_data = 12'hABC;
        inject = 1'b1;
        repeat (4) @(negedge clk);
        check("post_reset_late_done_no_valid", n_valid, v0);
        check("post_reset_ch1_data", 32'(ch1_data), 0);
        check("post_reset_idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
